// File: rtl/usb_cmd_rx_if.sv
// FX2 slave-FIFO read-side bus between the command receiver and the FX2 pins.
// The master modport is the receiver; the slave modport is the FIFO side.
interface usb_cmd_rx_if;
    logic        i_flag_ne;
    logic [15:0] i_data;
    logic        i_tx_busy;
    logic        o_rx_busy;
    logic [1:0]  o_addr;
    logic        o_sloe;
    logic        o_slrd;

    modport master (
        input  i_flag_ne, i_data, i_tx_busy,
        output o_rx_busy, o_addr, o_sloe, o_slrd
    );

    modport slave (
        output i_flag_ne, i_data, i_tx_busy,
        input  o_rx_busy, o_addr, o_sloe, o_slrd
    );
endinterface

// File: rtl/usb_cmd_rx.sv
// Reads 5-word command frames from the FX2 OUT FIFO, checks the XOR checksum
// and publishes the command; rejected or stalled frames pulse o_err.
module usb_cmd_rx #(
    parameter logic [15:0] SYNC_WORD = 16'hA55A,
    parameter logic [1:0]  EP_ADDR   = 2'b00,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              i_clk_usb,
    input  logic              i_rst,
    usb_cmd_rx_if.master      fx2,
    output logic [7:0]        o_cmd,
    output logic [31:0]       o_cmd_param,
    output logic              o_cmd_come,
    output logic              o_err,
    output logic [7:0]        o_err_cnt
);
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEL, RD, PROC} state_t;

    state_t        state, state_nx;
    logic [15:0]   word;
    logic [2:0]    idx;
    logic [15:0]   csum;
    logic [7:0]    cmd_buf;
    logic [31:0]   param_buf;
    logic [TW-1:0] tcnt;

    logic bus_ok, is_proc, timeout_hit, frame_ok, frame_bad, err_set;

    assign bus_ok      = fx2.i_flag_ne && !fx2.i_tx_busy;
    assign is_proc     = (state == PROC);
    assign timeout_hit = (state == IDLE) && (idx != 3'd0) && (tcnt == TLAST);
    assign frame_ok    = is_proc && (idx == 3'd4) && (word == csum);
    assign frame_bad   = is_proc && (idx == 3'd4) && (word != csum);
    assign err_set     = frame_bad || timeout_hit;

    always_ff @(posedge i_clk_usb) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    // Bus is only released at PROC, so a late i_tx_busy never cuts an access short
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus_ok) state_nx = SEL;
            SEL:     state_nx = RD;
            RD:      state_nx = PROC;
            PROC:    state_nx = bus_ok ? SEL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register
    always_ff @(posedge i_clk_usb) begin
        if (i_rst) begin
            fx2.o_rx_busy <= 1'b0;
            fx2.o_addr    <= EP_ADDR;
            fx2.o_sloe    <= 1'b1;
            fx2.o_slrd    <= 1'b1;
            word          <= 16'h0;
            idx           <= 3'd0;
            csum          <= 16'h0;
            cmd_buf       <= 8'h0;
            param_buf     <= 32'h0;
            tcnt          <= '0;
            o_cmd         <= 8'h0;
            o_cmd_param   <= 32'h0;
            o_cmd_come    <= 1'b0;
            o_err         <= 1'b0;
            o_err_cnt     <= 8'h0;
        end else begin
            fx2.o_rx_busy <= (state_nx != IDLE);
            fx2.o_addr    <= EP_ADDR;
            fx2.o_sloe    <= (state_nx == IDLE);
            fx2.o_slrd    <= (state_nx != RD);
            o_cmd_come    <= frame_ok;
            o_err         <= err_set;

            if (state == RD) word <= fx2.i_data;

            if (err_set && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;

            if (frame_ok) begin
                o_cmd       <= cmd_buf;
                o_cmd_param <= param_buf;
            end

            if (is_proc || timeout_hit)              tcnt <= '0;
            else if (state == IDLE && idx != 3'd0)   tcnt <= tcnt + TW'(1);

            // Index survives bus release; only a stall or a complete frame rewinds it
            if (timeout_hit) begin
                idx <= 3'd0;
            end else if (is_proc) begin
                case (idx)
                    3'd0: if (word == SYNC_WORD) begin
                        csum <= word;
                        idx  <= 3'd1;
                    end
                    3'd1: begin
                        csum    <= csum ^ word;
                        cmd_buf <= word[7:0];
                        idx     <= 3'd2;
                    end
                    3'd2: begin
                        csum             <= csum ^ word;
                        param_buf[31:16] <= word;
                        idx              <= 3'd3;
                    end
                    3'd3: begin
                        csum            <= csum ^ word;
                        param_buf[15:0] <= word;
                        idx             <= 3'd4;
                    end
                    default: idx <= 3'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_cmd_rx.sv
// Bench for usb_cmd_rx: an FX2 FIFO model feeds words, a table of frames is
// replayed, then stall, bus-contention, reset and saturation sequences.
module tb_usb_cmd_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd;
    logic [31:0] cmd_param;
    logic        cmd_come;
    logic        err;
    logic [7:0]  err_cnt;

    usb_cmd_rx_if bus();

    usb_cmd_rx dut (
        .i_clk_usb   (clk),
        .i_rst       (rst),
        .fx2         (bus),
        .o_cmd       (cmd),
        .o_cmd_param (cmd_param),
        .o_cmd_come  (cmd_come),
        .o_err       (err),
        .o_err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] w [7];
        logic [7:0]  cmd;
        logic [31:0] param;
        int          come;
        int          errs;
        logic [7:0]  ecnt;
        int          busy;
    } vec_t;

    logic [15:0] q[$];
    bit          pend = 1'b0;
    int          come_n = 0, err_n = 0, both_n = 0, busy_n = 0, rd_busy = 0;
    int          n_cmp = 0, n_bad = 0;
    vec_t        v [5];

    // FIFO model: a word is consumed once its RD cycle has completed
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (q.size() > 0) q.delete(0);
                pend = 1'b0;
            end
            if (!bus.o_slrd) begin
                pend = 1'b1;
                if (bus.i_tx_busy) rd_busy++;
            end
        end
        if (cmd_come) come_n++;
        if (err) err_n++;
        if (cmd_come && err) both_n++;
        if (bus.o_rx_busy) busy_n++;
        bus.i_flag_ne = (q.size() != 0);
        bus.i_data    = (q.size() != 0) ? q[0] : 16'h0;
    end

    function automatic vec_t mk(int n, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                                logic [15:0] d, logic [15:0] e, logic [15:0] f, logic [15:0] g,
                                logic [7:0] ec, logic [31:0] ep, int cm, int er,
                                logic [7:0] cnt, int bz);
        vec_t r;
        r.n = n;
        r.w[0] = a; r.w[1] = b; r.w[2] = c; r.w[3] = d; r.w[4] = e; r.w[5] = f; r.w[6] = g;
        r.cmd = ec; r.param = ep; r.come = cm; r.errs = er; r.ecnt = cnt; r.busy = bz;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        come_n = 0; err_n = 0; busy_n = 0; rd_busy = 0;
    endtask

    task automatic push(input vec_t x, input int cnt);
        for (int i = 0; i < cnt; i++) q.push_back(x.w[i]);
    endtask

    task automatic wait_done(input int maxc);
        int c = 0;
        while (!(q.size() == 0 && !pend && !bus.o_rx_busy) && c < maxc) begin
            tick(1);
            c++;
        end
        chk("done_in_budget", 32'(c < maxc), 32'd1);
        tick(3);
    endtask

    task automatic wait_rd(input int k);
        int seen = 0;
        int c = 0;
        while (seen < k && c < 100) begin
            tick(1);
            if (!bus.o_slrd) seen++;
            c++;
        end
        chk("rd_reached", 32'(seen), 32'(k));
    endtask

    initial begin
        rst = 1'b1;
        bus.i_tx_busy = 1'b0;

        v[0] = mk(5, 16'hA55A, 16'h0107, 16'h1234, 16'h5678, 16'hE011, 16'h0, 16'h0,
                  8'h07, 32'h12345678, 1, 0, 8'd0, 15);
        v[1] = mk(7, 16'h0000, 16'hFFFF, 16'hA55A, 16'h0242, 16'hDEAD, 16'hBEEF, 16'hC75A,
                  8'h42, 32'hDEADBEEF, 1, 0, 8'd0, 21);
        v[2] = mk(5, 16'hA55A, 16'h0107, 16'h1234, 16'h5678, 16'hE010, 16'h0, 16'h0,
                  8'h42, 32'hDEADBEEF, 0, 1, 8'd1, 15);
        v[3] = mk(5, 16'hA55A, 16'hA55A, 16'hA55A, 16'h0000, 16'hA55A, 16'h0, 16'h0,
                  8'h5A, 32'hA55A0000, 1, 0, 8'd1, 15);
        v[4] = mk(5, 16'hA55A, 16'h0107, 16'h1234, 16'h5678, 16'hE011, 16'h0, 16'h0,
                  8'h07, 32'h12345678, 1, 0, 8'd1, 15);

        tick(3);
        chk("rst_sloe", 32'(bus.o_sloe), 32'd1);
        chk("rst_slrd", 32'(bus.o_slrd), 32'd1);
        chk("rst_addr", 32'(bus.o_addr), 32'd0);
        chk("rst_rx_busy", 32'(bus.o_rx_busy), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_param", cmd_param, 32'd0);
        chk("rst_come", 32'(cmd_come), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 5; i++) begin
            clr();
            push(v[i], v[i].n);
            wait_done(200);
            chk($sformatf("v%0d_cmd", i), 32'(cmd), 32'(v[i].cmd));
            chk($sformatf("v%0d_param", i), cmd_param, v[i].param);
            chk($sformatf("v%0d_come", i), 32'(come_n), 32'(v[i].come));
            chk($sformatf("v%0d_err", i), 32'(err_n), 32'(v[i].errs));
            chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(v[i].ecnt));
            chk($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(v[i].busy));
            chk($sformatf("v%0d_sloe_idle", i), 32'(bus.o_sloe), 32'd1);
        end

        // Stall after W2: no error before the timeout, exactly one after
        clr();
        push(v[0], 3);
        wait_done(100);
        tick(1000);
        chk("to_early_err", 32'(err_n), 32'd0);
        tick(100);
        chk("to_err", 32'(err_n), 32'd1);
        chk("to_err_cnt", 32'(err_cnt), 32'd2);
        push(v[1], v[1].n);
        wait_done(200);
        chk("to_next_cmd", 32'(cmd), 32'h42);
        chk("to_next_param", cmd_param, 32'hDEADBEEF);
        chk("to_next_come", 32'(come_n), 32'd1);

        // Writer grabs the bus during RD of W1
        clr();
        push(v[0], 5);
        wait_rd(2);
        bus.i_tx_busy = 1'b1;
        tick(20);
        chk("busy_fifo_left", 32'(q.size()), 32'd3);
        chk("busy_rx_released", 32'(bus.o_rx_busy), 32'd0);
        chk("busy_sloe", 32'(bus.o_sloe), 32'd1);
        chk("busy_rd_count", 32'(rd_busy), 32'd1);
        chk("busy_no_come", 32'(come_n), 32'd0);
        bus.i_tx_busy = 1'b0;
        wait_done(200);
        chk("busy_cmd", 32'(cmd), 32'h07);
        chk("busy_param", cmd_param, 32'h12345678);
        chk("busy_come", 32'(come_n), 32'd1);

        // Reset during W3 drops the frame silently
        clr();
        push(v[3], 5);
        wait_rd(4);
        rst = 1'b1;
        q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("mrst_cmd", 32'(cmd), 32'd0);
        chk("mrst_param", cmd_param, 32'd0);
        chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("mrst_rx_busy", 32'(bus.o_rx_busy), 32'd0);
        chk("mrst_slrd", 32'(bus.o_slrd), 32'd1);
        chk("mrst_err", 32'(err_n), 32'd0);
        push(v[0], 5);
        wait_done(200);
        chk("mrst_next_cmd", 32'(cmd), 32'h07);
        chk("mrst_next_param", cmd_param, 32'h12345678);
        chk("mrst_next_come", 32'(come_n), 32'd1);

        // 256 bad frames drive the error counter into saturation
        clr();
        for (int i = 0; i < 256; i++) push(v[2], 5);
        wait_done(5000);
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
        chk("sat_err_pulses", 32'(err_n), 32'd256);
        chk("sat_no_come", 32'(come_n), 32'd0);
        chk("sat_cmd_held", 32'(cmd), 32'h07);

        chk("come_err_exclusive", 32'(both_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
